reset_release_sequencer: RTL and testbench
==========================================

# reset_release_sequencer

Sequences release of active-high resets to `N_DOMAINS` downstream subdomains, each driven through single-bit async-reset register stages. On global reset deassertion it synchronizes the release, then takes domains out of reset one at a time in index order, waiting for each domain's ready acknowledge (with timeout) before moving to the next. After power-on it accepts soft-reset requests that re-run the same assert/release sequence on a masked subset of domains. It sits between the top-level reset and the per-domain reset trees.

## Interface
- `N_DOMAINS`, 4, number of controlled subdomains (1..16)
- `SYNC_STAGES`, 3, reset-deassertion synchronizer depth (>=2)
- `HOLD_CYCLES`, 8, cycles domain resets are held asserted before the first release (>=1)
- `TIMEOUT`, 64, max cycles to wait for a domain ack (>=1)
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high
- `io_req_valid`  in  1  soft-reset request
- `io_req_ready`  out  1  request accepted when valid&&ready at a rising edge
- `io_req_mask`  in  N_DOMAINS  domains to soft-reset; sampled on acceptance
- `io_domain_ack`  in  N_DOMAINS  domain i is out of reset; synchronous to `clock` (caller synchronizes)
- `io_domain_reset`  out  N_DOMAINS  active-high reset to domain i, registered
- `io_busy`  out  1  sequence in progress
- `io_done`  out  1  one-cycle pulse at sequence completion
- `io_timeout`  out  N_DOMAINS  sticky: domain i missed its ack deadline

## Operation
- Reset values (asynchronous, immediate on `reset` high): `io_domain_reset` all ones, `io_req_ready`=0, `io_busy`=1, `io_done`=0, `io_timeout`=0, synchronizer chain all ones, state SYNC, active mask all ones, counters 0.
- States: SYNC, ASSERT, RELEASE, WAIT_ACK, IDLE.
- SYNC: wait until synchronized reset (last chain stage) is 0, then -> ASSERT.
- ASSERT: count HOLD_CYCLES cycles with masked resets held, then -> RELEASE with index = lowest set bit of active mask.
- RELEASE (1 cycle): clear `io_domain_reset[index]`, clear wait counter, -> WAIT_ACK.
- WAIT_ACK: each cycle, if `io_domain_ack[index]`=1 -> advance; else if wait counter reaches TIMEOUT set `io_timeout[index]` and advance; else increment. Ack and timeout in same cycle: ack wins, no flag.
- Advance: next higher set bit of active mask -> RELEASE; none left -> IDLE, pulse `io_done`.
- IDLE: `io_req_ready`=1, `io_busy`=0. On accept with nonzero mask: latch mask as active mask, set `io_domain_reset` bits for masked domains (others untouched), clear `io_timeout` bits for masked domains, -> ASSERT. On accept with zero mask: stay IDLE, pulse `io_done` next cycle, nothing else changes.
- Unmasked domains are never touched during a soft sequence.
- Ack deassertion after a domain's wait completes is ignored.
- `reset` asserted mid-sequence: immediate return to reset values; full power-on sequence restarts on deassertion.

## Timing
- Edge numbering: edge 1 is the first rising edge after `reset` falls.
- Synchronized reset low after edge SYNC_STAGES; ASSERT occupies edges SYNC_STAGES+1..SYNC_STAGES+HOLD_CYCLES.
- Power-on, acks already high: `io_domain_reset[i]` falls after edge SYNC_STAGES+HOLD_CYCLES+1+2i; defaults: 12, 14, 16, 18.
- `io_done` high for the single cycle after edge SYNC_STAGES+HOLD_CYCLES+2N; default edge 19. `io_req_ready` high and `io_busy` low from that cycle.
- Soft request accepted at edge k: masked resets high after edge k; first masked domain released after edge k+HOLD_CYCLES+1; each further masked domain 2 cycles later, plus ack wait.
- Ack wait: at most TIMEOUT+1 cycles in WAIT_ACK per domain.
- `io_done` and `io_req_ready` never high in the same cycle as a nonzero-mask acceptance effect; `io_req_ready` low throughout non-IDLE states.

## Test plan
- Power-on, acks tied high, defaults -> resets fall after edges 12/14/16/18, `io_done` after edge 19, `io_timeout`=0.
- Power-on, `io_domain_ack[1]` held 0 -> domain 1 waits 64 cycles, `io_timeout`=4'b0010, domains 2,3 still released in order, done asserted.
- Soft request mask 4'b1010 at edge k, acks high -> bits 1,3 high after k; bit 1 falls after k+9, bit 3 after k+11; bits 0,2 stay 0; `io_timeout[1]` cleared.
- Soft request mask 0 -> no reset change, `io_done` pulses one cycle, `io_req_ready` stays 1.
- `reset` asserted during WAIT_ACK of domain 2 -> all `io_domain_reset` high immediately, `io_timeout` cleared, full sequence reruns after deassertion.
- Ack and timeout coincide on domain 0 -> no timeout flag, sequence advances normally.

Source files
------------

// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: synchronizes global reset deassertion, then releases
// per-domain resets one at a time in index order, waiting on each domain's ack.
module reset_release_sequencer #(
    parameter int N_DOMAINS   = 4,
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_req_valid,
    output logic                 io_req_ready,
    input  logic [N_DOMAINS-1:0] io_req_mask,
    input  logic [N_DOMAINS-1:0] io_domain_ack,
    output logic [N_DOMAINS-1:0] io_domain_reset,
    output logic                 io_busy,
    output logic                 io_done,
    output logic [N_DOMAINS-1:0] io_timeout
);

    localparam int IDX_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_ASSERT,
        ST_RELEASE,
        ST_WAIT_ACK,
        ST_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N_DOMAINS-1:0]   active_q, active_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_DOMAINS-1:0]   rst_q, rst_d;
    logic [N_DOMAINS-1:0]   timeout_q, timeout_d;
    logic                   done_q, done_d;

    logic [IDX_W-1:0]       first_idx;
    logic [IDX_W-1:0]       next_idx;
    logic                   next_found;
    logic                   advance;

    // Lowest set bit of the active mask, and the lowest set bit above the current index.
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = N_DOMAINS - 1; i >= 0; i--) begin
            if (active_q[i]) begin
                first_idx = IDX_W'(i);
                if (i > int'(idx_q)) begin
                    next_found = 1'b1;
                    next_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b0};
        active_d  = active_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rst_d     = rst_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        advance   = 1'b0;

        case (state_q)
            // The cycle that observes the synchronized release already counts as the first hold cycle.
            ST_SYNC: begin
                if (!sync_q[SYNC_STAGES-1]) begin
                    idx_d = first_idx;
                    if (HOLD_CYCLES == 1) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_ASSERT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_ASSERT: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    idx_d   = first_idx;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                rst_d[idx_q] = 1'b0;
                cnt_d        = '0;
                state_d      = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (io_domain_ack[idx_q]) begin
                    advance = 1'b1;
                end else if (cnt_q == WAIT_LAST) begin
                    timeout_d[idx_q] = 1'b1;
                    advance          = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (advance) begin
                    if (next_found) begin
                        idx_d   = next_idx;
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (io_req_valid) begin
                    if (|io_req_mask) begin
                        active_d  = io_req_mask;
                        rst_d     = rst_q | io_req_mask;
                        timeout_d = timeout_q & ~io_req_mask;
                        cnt_d     = '0;
                        state_d   = ST_ASSERT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SYNC;
            sync_q    <= '1;
            active_q  <= '1;
            idx_q     <= '0;
            cnt_q     <= '0;
            rst_q     <= '1;
            timeout_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            active_q  <= active_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rst_q     <= rst_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    assign io_domain_reset = rst_q;
    assign io_timeout      = timeout_q;
    assign io_done         = done_q;
    assign io_req_ready    = (state_q == ST_IDLE);
    assign io_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer with default parameters; edges are
// counted from reset deassertion and outputs sampled 1 time unit after each edge.
module tb_reset_release_sequencer;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         io_req_valid = 1'b0;
    logic [N-1:0] io_req_mask = '0;
    logic [N-1:0] io_domain_ack = '1;
    logic         io_req_ready;
    logic [N-1:0] io_domain_reset;
    logic         io_busy;
    logic         io_done;
    logic [N-1:0] io_timeout;

    int checks = 0;
    int failures = 0;
    int edge_num = 0;
    logic [N-1:0] exp_rst;

    reset_release_sequencer #(
        .N_DOMAINS  (N),
        .SYNC_STAGES(3),
        .HOLD_CYCLES(8),
        .TIMEOUT    (64)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_req_valid   (io_req_valid),
        .io_req_ready   (io_req_ready),
        .io_req_mask    (io_req_mask),
        .io_domain_ack  (io_domain_ack),
        .io_domain_reset(io_domain_reset),
        .io_busy        (io_busy),
        .io_done        (io_done),
        .io_timeout     (io_timeout)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, observed, expected, edge_num);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [N-1:0] mask, input logic [N-1:0] ack);
        io_req_valid  = valid;
        io_req_mask   = mask;
        io_domain_ack = ack;
    endtask

    task automatic stepEdge();
        @(posedge clock);
        edge_num++;
        #1;
    endtask

    task automatic runToEdge(input int n);
        while (edge_num < n) stepEdge();
    endtask

    task automatic releaseReset();
        @(negedge clock);
        reset    = 1'b0;
        edge_num = 0;
    endtask

    task automatic assertReset();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values
        applyStimulus(1'b0, '0, '1);
        #12;
        checkOutput("rst_domain_reset", io_domain_reset, 4'hF);
        checkOutput("rst_ready", io_req_ready, 1'b0);
        checkOutput("rst_busy", io_busy, 1'b1);
        checkOutput("rst_done", io_done, 1'b0);
        checkOutput("rst_timeout", io_timeout, 4'h0);

        // Power-on with all acks high: releases after edges 12/14/16/18, done after 19
        releaseReset();
        for (int e = 1; e <= 20; e++) begin
            stepEdge();
            exp_rst = 4'hF;
            for (int d = 0; d < N; d++)
                if (e >= 12 + 2 * d) exp_rst[d] = 1'b0;
            checkOutput("po_domain_reset", io_domain_reset, exp_rst);
            checkOutput("po_done", io_done, (e == 19));
            checkOutput("po_ready", io_req_ready, (e >= 19));
            checkOutput("po_busy", io_busy, (e < 19));
        end
        checkOutput("po_timeout", io_timeout, 4'h0);

        // Zero-mask soft request: done pulse only
        applyStimulus(1'b1, 4'b0000, '1);
        stepEdge();
        checkOutput("zm_done", io_done, 1'b1);
        checkOutput("zm_ready", io_req_ready, 1'b1);
        checkOutput("zm_domain_reset", io_domain_reset, 4'h0);
        applyStimulus(1'b0, '0, '1);
        stepEdge();
        checkOutput("zm_done_end", io_done, 1'b0);
        checkOutput("zm_ready_end", io_req_ready, 1'b1);

        // Power-on with domain 1 never acking: times out, others still released
        applyStimulus(1'b0, '0, 4'b1101);
        assertReset();
        checkOutput("to_async_reset", io_domain_reset, 4'hF);
        checkOutput("to_async_busy", io_busy, 1'b1);
        releaseReset();
        runToEdge(12);
        checkOutput("to_rel0", io_domain_reset, 4'b1110);
        runToEdge(14);
        checkOutput("to_rel1", io_domain_reset, 4'b1100);
        runToEdge(78);
        checkOutput("to_flag_before", io_timeout, 4'b0000);
        stepEdge();
        checkOutput("to_flag_set", io_timeout, 4'b0010);
        checkOutput("to_hold2", io_domain_reset, 4'b1100);
        runToEdge(80);
        checkOutput("to_rel2", io_domain_reset, 4'b1000);
        runToEdge(82);
        checkOutput("to_rel3", io_domain_reset, 4'b0000);
        checkOutput("to_done_early", io_done, 1'b0);
        stepEdge();
        checkOutput("to_done", io_done, 1'b1);
        checkOutput("to_flag_kept", io_timeout, 4'b0010);
        stepEdge();
        checkOutput("to_done_end", io_done, 1'b0);

        // Soft request mask 1010 accepted at edge 85
        applyStimulus(1'b1, 4'b1010, '1);
        stepEdge();
        checkOutput("sr_assert", io_domain_reset, 4'b1010);
        checkOutput("sr_timeout_clr", io_timeout, 4'b0000);
        checkOutput("sr_ready", io_req_ready, 1'b0);
        checkOutput("sr_busy", io_busy, 1'b1);
        checkOutput("sr_done", io_done, 1'b0);
        applyStimulus(1'b0, '0, '1);
        runToEdge(93);
        checkOutput("sr_hold", io_domain_reset, 4'b1010);
        stepEdge();
        checkOutput("sr_rel1", io_domain_reset, 4'b1000);
        stepEdge();
        checkOutput("sr_wait3", io_domain_reset, 4'b1000);
        stepEdge();
        checkOutput("sr_rel3", io_domain_reset, 4'b0000);
        stepEdge();
        checkOutput("sr_done_pulse", io_done, 1'b1);
        checkOutput("sr_ready_end", io_req_ready, 1'b1);
        stepEdge();
        checkOutput("sr_done_end", io_done, 1'b0);

        // Reset asserted while waiting on domain 2, then full rerun
        applyStimulus(1'b0, '0, 4'b1001);
        assertReset();
        releaseReset();
        runToEdge(79);
        checkOutput("mr_flag1", io_timeout, 4'b0010);
        runToEdge(85);
        checkOutput("mr_waiting", io_domain_reset, 4'b1000);
        checkOutput("mr_busy", io_busy, 1'b1);
        #2;
        assertReset();
        checkOutput("mr_async_reset", io_domain_reset, 4'hF);
        checkOutput("mr_async_timeout", io_timeout, 4'h0);
        checkOutput("mr_async_ready", io_req_ready, 1'b0);
        checkOutput("mr_async_done", io_done, 1'b0);
        applyStimulus(1'b0, '0, '1);
        releaseReset();
        runToEdge(11);
        checkOutput("mr_rerun_hold", io_domain_reset, 4'hF);
        stepEdge();
        checkOutput("mr_rerun_rel0", io_domain_reset, 4'b1110);
        runToEdge(18);
        checkOutput("mr_rerun_rel3", io_domain_reset, 4'b0000);
        stepEdge();
        checkOutput("mr_rerun_done", io_done, 1'b1);

        // Ack on domain 0 arrives exactly on its timeout cycle: ack wins
        applyStimulus(1'b0, '0, 4'b1110);
        assertReset();
        releaseReset();
        runToEdge(12);
        checkOutput("co_rel0", io_domain_reset, 4'b1110);
        runToEdge(76);
        checkOutput("co_still_wait", io_domain_reset, 4'b1110);
        checkOutput("co_no_flag_yet", io_timeout, 4'b0000);
        applyStimulus(1'b0, '0, '1);
        stepEdge();
        checkOutput("co_no_flag", io_timeout, 4'b0000);
        stepEdge();
        checkOutput("co_rel1", io_domain_reset, 4'b1100);
        runToEdge(83);
        checkOutput("co_done", io_done, 1'b1);
        checkOutput("co_final_reset", io_domain_reset, 4'b0000);
        checkOutput("co_final_timeout", io_timeout, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
